// File: rtl/matr_pkg.sv
// Shared definitions for the matr sequencer.
// Holds the default geometry, the MATR instruction encoding and the
// sequencer state enum.
package matr_pkg;

    localparam int unsigned DefaultN     = 3;
    localparam int unsigned DefaultDataW = 32;
    localparam int unsigned DefaultIdxW  = 2;

    // Encoding of `matr rd, rs1, rs2` as issued by the program.
    localparam logic [6:0] MatrOpcode = 7'b0110011;
    localparam logic [6:0] MatrFunct7 = 7'b0000000;
    localparam logic [2:0] MatrFunct3 = 3'b001;

    typedef enum logic [2:0] {
        StIdle,
        StRdA,
        StRdB,
        StMac,
        StWrC,
        StDone
    } matr_state_e;

endpackage

// File: rtl/matr_addr_gen.sv
// Combinational element address: base + ((row * N + col) << 2).
// Ports:
//   base  byte address of element [0][0]
//   row   row index
//   col   column index
//   addr  byte address of element [row][col], wraps mod 2^ADDR_W
module matr_addr_gen #(
    parameter int unsigned N      = 3,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned IDX_W  = 2
) (
    input  logic [ADDR_W-1:0] base,
    input  logic [IDX_W-1:0]  row,
    input  logic [IDX_W-1:0]  col,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] word_idx;

    assign word_idx = ADDR_W'(row) * ADDR_W'(N) + ADDR_W'(col);
    assign addr     = base + (word_idx << 2);

endmodule

// File: rtl/matr_seq.sv
// Multi-cycle sequencer for `matr rd, rs1, rs2`: C = A x B on N x N
// row-major word matrices in data memory. While busy it owns the
// data-memory port and freezes the pipeline; it ends with a one-cycle done.
// Ports:
//   clk_50, rst_n        clock, async active-low reset
//   start                instruction issued (sampled in idle only)
//   base_a/base_b/base_c byte addresses of A, B, C
//   stall                pipeline freeze = start | busy
//   busy                 sequencer active / data-memory mux select
//   done                 completion pulse
//   mem_addr/rd/wr/wdata data-memory request, mem_rdata 1-cycle read data
module matr_seq
    import matr_pkg::*;
#(
    parameter int unsigned N      = DefaultN,
    parameter int unsigned DATA_W = DefaultDataW,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned IDX_W  = DefaultIdxW
) (
    input  logic              clk_50,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [ADDR_W-1:0] base_c,
    output logic              stall,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [IDX_W-1:0] IdxLast = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] IdxOne  = IDX_W'(1);

    matr_state_e state_q, state_d;
    logic [IDX_W-1:0]  i_q, i_d, j_q, j_d, k_q, k_d;
    logic [DATA_W-1:0] acc_q, acc_d, a_reg_q, a_reg_d;
    logic [ADDR_W-1:0] base_a_q, base_a_d, base_b_q, base_b_d, base_c_q, base_c_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] addr_a, addr_b, addr_c;

    matr_addr_gen #(.N(N), .ADDR_W(ADDR_W), .IDX_W(IDX_W)) u_addr_a (
        .base (base_a_q),
        .row  (i_q),
        .col  (k_q),
        .addr (addr_a)
    );

    matr_addr_gen #(.N(N), .ADDR_W(ADDR_W), .IDX_W(IDX_W)) u_addr_b (
        .base (base_b_q),
        .row  (k_q),
        .col  (j_q),
        .addr (addr_b)
    );

    matr_addr_gen #(.N(N), .ADDR_W(ADDR_W), .IDX_W(IDX_W)) u_addr_c (
        .base (base_c_q),
        .row  (i_q),
        .col  (j_q),
        .addr (addr_c)
    );

    assign busy      = (state_q != StIdle);
    assign stall     = start | busy;
    assign mem_wdata = acc_q;

    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        j_d      = j_q;
        k_d      = k_q;
        acc_d    = acc_q;
        a_reg_d  = a_reg_q;
        base_a_d = base_a_q;
        base_b_d = base_b_q;
        base_c_d = base_c_q;
        addr_d   = addr_q;
        mem_addr = addr_q; // held while idle/done
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        done     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    base_a_d = base_a;
                    base_b_d = base_b;
                    base_c_d = base_c;
                    i_d      = '0;
                    j_d      = '0;
                    k_d      = '0;
                    acc_d    = '0;
                    state_d  = StRdA;
                end
            end
            StRdA: begin
                mem_rd   = 1'b1;
                mem_addr = addr_a;
                addr_d   = addr_a;
                state_d  = StRdB;
            end
            StRdB: begin
                mem_rd   = 1'b1;
                mem_addr = addr_b;
                addr_d   = addr_b;
                a_reg_d  = mem_rdata; // A word from the RD_A request
                state_d  = StMac;
            end
            StMac: begin
                // mem_rdata now carries the B word; truncation makes this sign-agnostic.
                acc_d = acc_q + a_reg_q * mem_rdata;
                if (k_q == IdxLast) begin
                    state_d = StWrC;
                end else begin
                    k_d     = k_q + IdxOne;
                    state_d = StRdA;
                end
            end
            StWrC: begin
                mem_wr   = 1'b1;
                mem_addr = addr_c;
                addr_d   = addr_c;
                k_d      = '0;
                acc_d    = '0;
                if (j_q < IdxLast) begin
                    j_d     = j_q + IdxOne;
                    state_d = StRdA;
                end else if (i_q < IdxLast) begin
                    j_d     = '0;
                    i_d     = i_q + IdxOne;
                    state_d = StRdA;
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            acc_q    <= '0;
            a_reg_q  <= '0;
            base_a_q <= '0;
            base_b_q <= '0;
            base_c_q <= '0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            j_q      <= j_d;
            k_q      <= k_d;
            acc_q    <= acc_d;
            a_reg_q  <= a_reg_d;
            base_a_q <= base_a_d;
            base_b_q <= base_b_d;
            base_c_q <= base_c_d;
            addr_q   <= addr_d;
        end
    end

endmodule

// File: doc/matr_seq.md
Name: matr_seq

Overview:
- Multi-cycle sequencer that executes the custom `matr rd, rs1, rs2` instruction: C = A × B on N×N row-major word matrices held in data memory.
- While the decode/EX stage asserts `start`, the block freezes the pipeline.
- It takes ownership of the data-memory port and walks i/j/k loops: read A, read B, multiply-accumulate, write C.
- It releases the pipeline with a one-cycle `done` pulse.

Parameters:
- N, 3, matrix dimension (square).
- DATA_W, 32, element and accumulator width.
- ADDR_W, 32, byte-address width.
- IDX_W, 2, loop-index width; must satisfy 2^IDX_W > N-1.

Ports:
- clk_50  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  matr issued; sampled only in IDLE.
- base_a  in  ADDR_W  byte address of A[0][0] (rs1 value).
- base_b  in  ADDR_W  byte address of B[0][0] (rs2 value).
- base_c  in  ADDR_W  byte address of C[0][0] (rd value).
- stall  out  1  pipeline freeze = start | busy (combinational).
- busy  out  1  state != IDLE; also the data-memory mux select (sequencer owns the port).
- done  out  1  one-cycle completion pulse.
- mem_addr  out  ADDR_W  data-memory byte address.
- mem_rd  out  1  read strobe; data returns on mem_rdata the following cycle.
- mem_wr  out  1  write strobe, single cycle.
- mem_wdata  out  DATA_W  write data (accumulator).
- mem_rdata  in  DATA_W  read data, 1-cycle synchronous latency.

Behaviour:
- Reset (async, any state): state=IDLE; i=j=k=0; acc=0; a_reg=0; base latches=0.
- Reset values of outputs: busy=0, done=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0. stall follows start.
- Reset mid-operation: immediate abort. C words already written stay written, with no partial write. The next start restarts from i=j=k=0.
- States are IDLE, RD_A, RD_B, MAC, WR_C, DONE.
- IDLE:
  - On start=1, latch base_a/b/c; clear i, j, k, acc.
  - Go to RD_A.
- RD_A:
  - mem_rd=1, mem_addr = base_a + ((i*N + k) << 2).
  - Go to RD_B.
- RD_B:
  - mem_rd=1, mem_addr = base_b + ((k*N + j) << 2).
  - a_reg <= mem_rdata.
  - Go to MAC.
- MAC:
  - acc <= acc + a_reg*mem_rdata. The product and sum are truncated to DATA_W (mod 2^DATA_W), so the result is sign-agnostic.
  - If k==N-1: go to WR_C.
  - Else: k++, go to RD_A.
- WR_C:
  - mem_wr=1, mem_addr = base_c + ((i*N + j) << 2), mem_wdata=acc.
  - Then k=0, acc=0.
  - If j<N-1: j++, go to RD_A.
  - Else if i<N-1: j=0, i++, go to RD_A.
  - Else: go to DONE.
- DONE:
  - done=1 for exactly one cycle; busy=1 in this cycle.
  - Go to IDLE.
- mem_rd and mem_wr are never high together. Both are 0 in IDLE and DONE, and mem_addr holds its last value there.
- Latency:
  - 3N+1 cycles per C element.
  - done is asserted in the (N²(3N+1)+1)th cycle after the edge that sampled start (91 for N=3).
  - busy falls the cycle after done.
- start while busy is ignored; it only holds stall high.
- start in the cycle done is high is ignored; start in the following IDLE cycle is accepted (back-to-back).
- In-place overlap (C aliasing A or B) is not protected: results follow the access order above.
- Address arithmetic wraps mod 2^ADDR_W.

Decomposition:
- Shared package (matr_pkg):
  - State enum constants.
  - MATR opcode/funct constants (opcode 0110011, funct7 0000000, funct3 001 as issued by the program).
  - Default N, DATA_W, IDX_W.
- One natural sub-module: matr_addr_gen, combinational base + ((row*N + col) << 2). It is instanced for the A, B and C address forms.

Test Plan:
- A=[1..9] at base 0, B=[9..1] at base 36, base_c=72, pulse start:
  - C words at 72..104 = 30,24,18,84,69,54,138,114,90.
  - done at cycle 91; exactly 9 mem_wr pulses.
- A=identity, B=[5..13]: C == B word-for-word.
- start pulsed repeatedly at cycles 10, 50, 90 after the first accept:
  - Single run, one done, no restart of indices.
  - stall high throughout.
- rst_n asserted low at cycle 40:
  - All outputs 0 immediately; C[0..2] written, C[3..8] untouched.
  - A fresh start completes a full, correct C.
- A[0][*]=0xFFFFFFFF, B[*][0]=2, rest 0: C[0][0] = 0xFFFFFFFA (wrap).
- Back-to-back: start re-asserted the cycle after done with new bases: second C correct, second done 92 cycles after the first.
